// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state/size encodings and helpers for the memory access stage
package mem_pkg;
    localparam int XLEN = 64;
    localparam int LS_W = 11;
    localparam int LS_LB  = 0;
    localparam int LS_LH  = 1;
    localparam int LS_LW  = 2;
    localparam int LS_LD  = 3;
    localparam int LS_LBU = 4;
    localparam int LS_LHU = 5;
    localparam int LS_LWU = 6;
    localparam int LS_SB  = 7;
    localparam int LS_SH  = 8;
    localparam int LS_SW  = 9;
    localparam int LS_SD  = 10;
    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
    function automatic logic [7:0] strb_base(input size_t s);
        return s == SZ_B ? STRB_B : s == SZ_H ? STRB_H : s == SZ_W ? STRB_W : STRB_D;
    endfunction
    function automatic logic misaligned(input size_t s, input logic [2:0] off);
        return s == SZ_H ? off[0] : s == SZ_W ? |off[1:0] : s == SZ_D ? |off : 1'b0;
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: valid/ready data-memory request channel plus response channel
interface mem_access_unit_if;
    import mem_pkg::*;
    logic            dmem_o_req_valid;
    logic            dmem_i_req_ready;
    logic [XLEN-1:0] dmem_o_addr;
    logic            dmem_o_wen;
    logic [XLEN-1:0] dmem_o_wdata;
    logic [7:0]      dmem_o_wstrb;
    logic            dmem_i_resp_valid;
    logic [XLEN-1:0] dmem_i_rdata;
    modport master (
        output dmem_o_req_valid, dmem_o_addr, dmem_o_wen, dmem_o_wdata, dmem_o_wstrb,
        input  dmem_i_req_ready, dmem_i_resp_valid, dmem_i_rdata
    );
    modport slave (
        input  dmem_o_req_valid, dmem_o_addr, dmem_o_wen, dmem_o_wdata, dmem_o_wstrb,
        output dmem_i_req_ready, dmem_i_resp_valid, dmem_i_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: byte-lane shift and sign/zero extension of 64-bit read data
module mem_load_align import mem_pkg::*; (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_off,
    input  size_t           i_size,
    input  logic            i_sign,
    output logic [XLEN-1:0] o_data
);
    logic [XLEN-1:0] w_sh;
    // Move the addressed byte to lane 0, then extend from the access size
    always_comb begin
        w_sh = i_rdata >> {i_off, 3'b000};
        o_data = i_size == SZ_B ? {{56{i_sign & w_sh[7]}}, w_sh[7:0]} :
                 i_size == SZ_H ? {{48{i_sign & w_sh[15]}}, w_sh[15:0]} :
                 i_size == SZ_W ? {{32{i_sign & w_sh[31]}}, w_sh[31:0]} : w_sh;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer; optional MEM_MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_unit import mem_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic [LS_W-1:0]  regM_i_load_store_info,
    input  logic [XLEN-1:0]  regM_i_regdata2,
    input  logic [XLEN-1:0]  regM_i_alu_result,
    input  logic [4:0]       regM_i_rd,
    input  logic             regM_i_reg_wen,
    input  logic             regM_i_commit,
    mem_access_unit_if.master dmem,
    output logic             memory_o_stall,
    output logic [XLEN-1:0]  memory_o_result,
    output logic [4:0]       memory_o_rd,
    output logic             memory_o_reg_wen,
    output logic             memory_o_commit
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic             memory_o_misalign
`endif
);
    state_t          r_state, w_next;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
    logic [7:0]      r_wstrb;
    size_t           r_size;
    logic            r_sign, r_wen, r_misalign;
    logic            w_start, w_is_store, w_sign, w_trap, w_stall, w_use_ld, w_trap_done;
    size_t           w_size;
    logic [2:0]      w_off;
    logic [XLEN-1:0] w_wdata, w_ld_data;
    logic [7:0]      w_wstrb;
    wire [LS_W-1:0]  w_ls = regM_i_load_store_info;

    // rst gates the start condition so stall drops in the same cycle reset is asserted
    assign w_start    = !rst && regM_i_commit && |w_ls;
    assign w_is_store = |w_ls[LS_SD:LS_SB];
    assign w_sign     = w_ls[LS_LB] | w_ls[LS_LH] | w_ls[LS_LW];
    assign w_size     = (w_ls[LS_LB] | w_ls[LS_LBU] | w_ls[LS_SB]) ? SZ_B :
                        (w_ls[LS_LH] | w_ls[LS_LHU] | w_ls[LS_SH]) ? SZ_H :
                        (w_ls[LS_LW] | w_ls[LS_LWU] | w_ls[LS_SW]) ? SZ_W : SZ_D;
    assign w_off      = regM_i_alu_result[2:0];
    assign w_wdata    = regM_i_regdata2 << {w_off, 3'b000};
    assign w_wstrb    = w_is_store ? strb_base(w_size) << w_off : 8'h00;
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap            = misaligned(w_size, w_off);
    assign memory_o_misalign = w_trap_done;
`else
    assign w_trap = 1'b0;
`endif

    // Next-state and stall decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: w_next = w_start ? (w_trap ? ST_DONE : ST_REQ) : ST_IDLE;
            ST_REQ:  w_next = dmem.dmem_i_req_ready ? ST_RESP : ST_REQ;
            ST_RESP: w_next = dmem.dmem_i_resp_valid ? ST_DONE : ST_RESP;
            default: w_next = ST_IDLE;
        endcase
        w_stall     = (r_state == ST_IDLE && w_start) || r_state == ST_REQ || r_state == ST_RESP;
        w_trap_done = r_state == ST_DONE && r_misalign;
        w_use_ld    = r_state == ST_DONE && !r_wen && !r_misalign;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Capture the access on entry and the read data on response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_size     <= SZ_B;
            r_sign     <= 1'b0;
            r_wen      <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (r_state == ST_IDLE && w_start) begin
                r_addr     <= regM_i_alu_result;
                r_wdata    <= w_wdata;
                r_wstrb    <= w_wstrb;
                r_size     <= w_size;
                r_sign     <= w_sign;
                r_wen      <= w_is_store;
                r_misalign <= w_trap;
            end
            if (r_state == ST_RESP && dmem.dmem_i_resp_valid) r_rdata <= dmem.dmem_i_rdata;
        end
    end

    mem_load_align u_align (
        .i_rdata (r_rdata),
        .i_off   (r_addr[2:0]),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .o_data  (w_ld_data)
    );

    assign dmem.dmem_o_req_valid = r_state == ST_REQ;
    assign dmem.dmem_o_addr      = {r_addr[XLEN-1:3], 3'b000};
    assign dmem.dmem_o_wen       = r_wen;
    assign dmem.dmem_o_wdata     = r_wdata;
    assign dmem.dmem_o_wstrb     = r_wstrb;
    assign memory_o_stall        = w_stall;
    assign memory_o_result       = w_use_ld ? w_ld_data : regM_i_alu_result;
    assign memory_o_commit       = !w_stall && regM_i_commit;
    assign memory_o_rd           = w_stall ? 5'd0 : regM_i_rd;
    assign memory_o_reg_wen      = !w_stall && regM_i_reg_wen && !w_trap_done;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit (honours MEM_MISALIGN_TRAP_EN)
module tb_mem_access_unit;
    import mem_pkg::*;
    logic            clk = 1'b0;
    logic            rst;
    logic [LS_W-1:0] ls;
    logic [63:0]     d2, alu, result;
    logic [4:0]      rd_i, rd_o;
    logic            wen_i, commit_i, stall, wen_o, commit_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            misalign;
`endif
    int              errors = 0;
    int              checks = 0;
    logic [63:0]     sb_q[$];

    mem_access_unit_if dmem ();

    mem_access_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .regM_i_load_store_info (ls),
        .regM_i_regdata2        (d2),
        .regM_i_alu_result      (alu),
        .regM_i_rd              (rd_i),
        .regM_i_reg_wen         (wen_i),
        .regM_i_commit          (commit_i),
        .dmem                   (dmem),
        .memory_o_stall         (stall),
        .memory_o_result        (result),
        .memory_o_rd            (rd_o),
        .memory_o_reg_wen       (wen_o),
        .memory_o_commit        (commit_o)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .memory_o_misalign      (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input int bit_idx, input logic [63:0] addr, input logic [63:0] data2,
                          input logic [63:0] rdata, input int rdy_wait, input int resp_wait,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb, input logic exp_wen);
        int nst = 0;
        logic [63:0] exp_addr = {addr[63:3], 3'b000};
        ls = '0;
        ls[bit_idx] = 1'b1;
        alu = addr; d2 = data2; rd_i = 5'(bit_idx + 1); wen_i = 1'b1; commit_i = 1'b1;
        #1;
        check("idle_stall", stall, 1);
        check("idle_commit", commit_o, 0);
        nst += int'(stall);
        tick();
        repeat (rdy_wait) begin
            check("wait_valid", dmem.dmem_o_req_valid, 1);
            check("wait_addr", dmem.dmem_o_addr, exp_addr);
            check("wait_wdata", dmem.dmem_o_wdata, exp_wdata);
            check("wait_commit", commit_o, 0);
            nst += int'(stall);
            tick();
        end
        dmem.dmem_i_req_ready = 1'b1;
        #1;
        check("req_valid", dmem.dmem_o_req_valid, 1);
        check("req_addr", dmem.dmem_o_addr, exp_addr);
        check("req_wdata", dmem.dmem_o_wdata, exp_wdata);
        check("req_wstrb", dmem.dmem_o_wstrb, exp_wstrb);
        check("req_wen", dmem.dmem_o_wen, exp_wen);
        nst += int'(stall);
        tick();
        dmem.dmem_i_req_ready = 1'b0;
        repeat (resp_wait - 1) begin
            check("resp_wait_valid", dmem.dmem_o_req_valid, 0);
            nst += int'(stall);
            tick();
        end
        dmem.dmem_i_resp_valid = 1'b1;
        dmem.dmem_i_rdata = rdata;
        #1;
        nst += int'(stall);
        tick();
        dmem.dmem_i_resp_valid = 1'b0;
        dmem.dmem_i_rdata = {$urandom, $urandom};
        check("done_stall", stall, 0);
        check("done_commit", commit_o, 1);
        check("done_rd", rd_o, 64'(bit_idx + 1));
        check("done_reg_wen", wen_o, 1);
        check("stall_cycles", nst, 64'(2 + rdy_wait + resp_wait));
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) check("done_result", result, sb_q.pop_front());
        commit_i = 1'b0; ls = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1; ls = '0; d2 = '0; alu = '0; rd_i = '0; wen_i = 1'b0; commit_i = 1'b0;
        dmem.dmem_i_req_ready = 1'b0; dmem.dmem_i_resp_valid = 1'b0; dmem.dmem_i_rdata = '0;
        repeat (2) tick();
        check("rst_stall", stall, 0);
        check("rst_req_valid", dmem.dmem_o_req_valid, 0);
        check("rst_addr", dmem.dmem_o_addr, 0);
        check("rst_wdata", dmem.dmem_o_wdata, 0);
        check("rst_wstrb", dmem.dmem_o_wstrb, 0);
        check("rst_commit", commit_o, 0);
        rst = 1'b0;
        tick();
        ls = '0; alu = 64'h1234; commit_i = 1'b1; rd_i = 5'd7; wen_i = 1'b1;
        #1;
        check("pt_result", result, 64'h1234);
        check("pt_stall", stall, 0);
        check("pt_commit", commit_o, 1);
        check("pt_rd", rd_o, 7);
        check("pt_reg_wen", wen_o, 1);
        tick();
        check("pt_no_req", dmem.dmem_o_req_valid, 0);
        ls = 11'h004; commit_i = 1'b0;
        #1;
        check("nocommit_stall", stall, 0);
        check("nocommit_commit", commit_o, 0);
        tick();
        check("nocommit_no_req", dmem.dmem_o_req_valid, 0);
        ls = '0;
        sb_q.push_back(64'h1122334455667788);
        mem_op(LS_LD, 64'h1000, 64'h0, 64'h1122334455667788, 0, 1, 64'h0, 8'h00, 1'b0);
        sb_q.push_back(64'hFFFFFFFFFFFFFF80);
        mem_op(LS_LB, 64'h1003, 64'h0, 64'h0000000080000000, 0, 2, 64'h0, 8'h00, 1'b0);
        sb_q.push_back(64'h80);
        mem_op(LS_LBU, 64'h1003, 64'h0, 64'h0000000080000000, 1, 1, 64'h0, 8'h00, 1'b0);
        sb_q.push_back(64'h1006);
        mem_op(LS_SH, 64'h1006, 64'hABCD, 64'h0, 3, 2, 64'hABCD000000000000, 8'hC0, 1'b1);
        sb_q.push_back(64'hFFFFFFFF80000001);
        mem_op(LS_LW, 64'h1004, 64'h0, 64'h8000000100000000, 0, 1, 64'h0, 8'h00, 1'b0);
        sb_q.push_back(64'h0000000080000001);
        mem_op(LS_LWU, 64'h1004, 64'h0, 64'h8000000100000000, 2, 1, 64'h0, 8'h00, 1'b0);
        sb_q.push_back(64'hFFFFFFFFFFFFF00F);
        mem_op(LS_LH, 64'h1002, 64'h0, 64'h00000000F00F0000, 0, 3, 64'h0, 8'h00, 1'b0);
        sb_q.push_back(64'h1000);
        mem_op(LS_SD, 64'h1000, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 1, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
        sb_q.push_back(64'h1004);
        mem_op(LS_SW, 64'h1004, 64'h12345678, 64'h0, 1, 1, 64'h1234567800000000, 8'hF0, 1'b1);
        sb_q.push_back(64'h1007);
        mem_op(LS_SB, 64'h1007, 64'h5A, 64'h0, 0, 2, 64'h5A00000000000000, 8'h80, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        ls = 11'h004; alu = 64'h1002; commit_i = 1'b1; rd_i = 5'd9; wen_i = 1'b1;
        #1;
        check("trap_idle_stall", stall, 1);
        tick();
        check("trap_misalign", misalign, 1);
        check("trap_reg_wen", wen_o, 0);
        check("trap_commit", commit_o, 1);
        check("trap_stall", stall, 0);
        check("trap_no_req", dmem.dmem_o_req_valid, 0);
        commit_i = 1'b0; ls = '0;
        tick();
        check("trap_misalign_clr", misalign, 0);
        check("trap_no_req2", dmem.dmem_o_req_valid, 0);
`else
        sb_q.push_back(64'h1006);
        mem_op(LS_SW, 64'h1006, 64'h11223344, 64'h0, 0, 1, 64'h3344000000000000, 8'hC0, 1'b1);
`endif
        ls = 11'h008; alu = 64'h2008; d2 = '0; commit_i = 1'b1; rd_i = 5'd3; wen_i = 1'b1;
        dmem.dmem_i_req_ready = 1'b1;
        tick();
        tick();
        dmem.dmem_i_req_ready = 1'b0;
        check("resp_stall", stall, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req_valid", dmem.dmem_o_req_valid, 0);
        check("arst_stall", stall, 0);
        check("arst_addr", dmem.dmem_o_addr, 0);
        tick();
        ls = '0; commit_i = 1'b0; rst = 1'b0;
        dmem.dmem_i_resp_valid = 1'b1; dmem.dmem_i_rdata = 64'hDEAD;
        tick();
        dmem.dmem_i_resp_valid = 1'b0;
        check("stray_commit", commit_o, 0);
        check("stray_stall", stall, 0);
        check("stray_result", result, 64'h2008);
        tick();
        check("stray_commit2", commit_o, 0);
        check("stray_req_valid", dmem.dmem_o_req_valid, 0);
        check("stray_result2", result, 64'h2008);
        check("sb_final_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
